// File: rtl/if_pkg.sv
// Shared types and helpers for the instruction-fetch prefetch stage.
package if_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned INST_BYTES = 4;

  // One prefetch buffer slot: PC is written at grant, IR when the response lands.
  typedef struct packed {
    logic                filled;
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] ir;
  } fetch_entry_t;

  // Pointer width: index bits plus one wrap bit so full and empty are distinct.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// In-order circular prefetch buffer with separate alloc/fill/read pointers.
// alloc advances on grant, fill on an accepted response, read on a pop.
module if_fetch_buf
  import if_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = ptr_w(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic                alloc_i,
  input  logic [XLEN_DEF-1:0] alloc_pc_i,
  input  logic                fill_i,
  input  logic [XLEN_DEF-1:0] fill_ir_i,
  input  logic                pop_i,
  output logic [PtrW-1:0]     occupancy_o,
  output logic [PtrW-1:0]     outstanding_o,
  output logic                head_valid_o,
  output logic [XLEN_DEF-1:0] head_pc_o,
  output logic [XLEN_DEF-1:0] head_ir_o
);

  localparam int unsigned IdxW = PtrW - 1;

  logic [PtrW-1:0] alloc_q, alloc_d;
  logic [PtrW-1:0] fill_q, fill_d;
  logic [PtrW-1:0] read_q, read_d;
  logic [IdxW-1:0] alloc_idx, fill_idx, read_idx;
  fetch_entry_t    entries_q [DEPTH];

  assign alloc_idx = alloc_q[IdxW-1:0];
  assign fill_idx  = fill_q[IdxW-1:0];
  assign read_idx  = read_q[IdxW-1:0];

  // Pointer next-state; a flush returns every pointer to the origin.
  always_comb begin
    alloc_d = alloc_q;
    fill_d  = fill_q;
    read_d  = read_q;
    if (flush_i) begin
      alloc_d = '0;
      fill_d  = '0;
      read_d  = '0;
    end else begin
      if (alloc_i) alloc_d = alloc_q + PtrW'(1);
      if (fill_i)  fill_d  = fill_q + PtrW'(1);
      if (pop_i)   read_d  = read_q + PtrW'(1);
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_q <= '0;
      fill_q  <= '0;
      read_q  <= '0;
    end else begin
      alloc_q <= alloc_d;
      fill_q  <= fill_d;
      read_q  <= read_d;
    end
  end

  // Entry storage. alloc and fill never hit the same slot in one cycle: that
  // would need DEPTH requests outstanding, and issue is blocked then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) entries_q[i] <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < int'(DEPTH); i++) entries_q[i].filled <= 1'b0;
    end else begin
      if (alloc_i) begin
        entries_q[alloc_idx].pc     <= alloc_pc_i;
        entries_q[alloc_idx].filled <= 1'b0;
      end
      if (fill_i) begin
        entries_q[fill_idx].ir     <= fill_ir_i;
        entries_q[fill_idx].filled <= 1'b1;
      end
    end
  end

  assign occupancy_o   = alloc_q - read_q;
  assign outstanding_o = alloc_q - fill_q;
  assign head_valid_o  = (read_q != fill_q);
  assign head_pc_o     = entries_q[read_idx].pc;
  assign head_ir_o     = entries_q[read_idx].ir;

  // Fills are in order, so anything between read and fill must hold data.
  a_head_filled: assert property (@(posedge clk) disable iff (!rst_n)
    head_valid_o |-> entries_q[read_idx].filled);

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with a DEPTH-entry prefetch buffer supporting multiple
// outstanding requests. Redirects flush the buffer and count in-flight responses
// that must be discarded when they return.
module if_prefetch_stage
  import if_pkg::*;
#(
  parameter int unsigned     XLEN     = XLEN_DEF,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_take_branch_out,
  input  logic [XLEN-1:0] ex_target_PC_out,
  output logic            proc2Imem_req,
  output logic [XLEN-1:0] proc2Imem_addr,
  input  logic            Imem2proc_gnt,
  input  logic            Imem2proc_rvalid,
  input  logic [XLEN-1:0] Imem2proc_data,
  input  logic            id_ready,
  output logic            if_valid_inst_out,
  output logic [XLEN-1:0] if_PC_out,
  output logic [XLEN-1:0] if_NPC_out,
  output logic [XLEN-1:0] if_IR_out
);

  // Buffer storage is sized by XLEN_DEF; XLEN is expected to match it.
  localparam int unsigned   PtrW   = ptr_w(DEPTH);
  localparam logic [PtrW:0] DepthW = (PtrW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0] drop_cnt_q, drop_cnt_d;
  logic [PtrW-1:0] occupancy, outstanding;
  logic [PtrW:0]   in_use, drop_sum, drop_sum_adj;
  logic            grant, resp_drop, resp_fill, pop;
  logic            head_valid;
  logic [XLEN-1:0] head_pc, head_ir;

  // Slots still spoken for: live entries plus stale responses yet to arrive.
  assign in_use = {1'b0, occupancy} + {1'b0, drop_cnt_q};

  assign proc2Imem_req  = rst_n & ~ex_take_branch_out & (in_use < DepthW);
  assign proc2Imem_addr = {fetch_pc_q[XLEN-1:2], 2'b00};

  assign grant     = proc2Imem_req & Imem2proc_gnt;
  assign resp_drop = Imem2proc_rvalid & (drop_cnt_q != '0);
  assign resp_fill = Imem2proc_rvalid & ~ex_take_branch_out & (drop_cnt_q == '0) &
                     (outstanding != '0);
  assign pop       = head_valid & id_ready & ~ex_take_branch_out;

  // On redirect every in-flight live request turns stale; a response arriving
  // in the same cycle retires one of them immediately.
  assign drop_sum     = {1'b0, drop_cnt_q} + {1'b0, outstanding};
  assign drop_sum_adj = (Imem2proc_rvalid && drop_sum != '0) ? drop_sum - (PtrW + 1)'(1)
                                                              : drop_sum;

  // Fetch PC and drop counter next-state; redirect takes priority.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (ex_take_branch_out) begin
      fetch_pc_d = {ex_target_PC_out[XLEN-1:2], 2'b00};
      drop_cnt_d = drop_sum_adj[PtrW-1:0];
    end else begin
      if (grant)     fetch_pc_d = fetch_pc_q + XLEN'(INST_BYTES);
      if (resp_drop) drop_cnt_d = drop_cnt_q - PtrW'(1);
    end
  end

  // Fetch PC and drop counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  if_fetch_buf #(
    .DEPTH (DEPTH)
  ) u_fetch_buf (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush_i       (ex_take_branch_out),
    .alloc_i       (grant),
    .alloc_pc_i    (proc2Imem_addr),
    .fill_i        (resp_fill),
    .fill_ir_i     (Imem2proc_data),
    .pop_i         (pop),
    .occupancy_o   (occupancy),
    .outstanding_o (outstanding),
    .head_valid_o  (head_valid),
    .head_pc_o     (head_pc),
    .head_ir_o     (head_ir)
  );

  assign if_valid_inst_out = head_valid;
  assign if_PC_out         = head_pc;
  assign if_NPC_out        = head_pc + XLEN'(INST_BYTES);
  assign if_IR_out         = head_ir;

  // A response with nothing live or stale in flight is a memory protocol error.
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst_n)
    !(Imem2proc_rvalid && drop_cnt_q == '0 && outstanding == '0));

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Randomized bench for if_prefetch_stage against a queue-based reference model
// and an in-order variable-latency memory model.
module tb_if_prefetch_stage;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_take_branch_out;
  logic [31:0] ex_target_PC_out;
  logic        proc2Imem_req;
  logic [31:0] proc2Imem_addr;
  logic        Imem2proc_gnt;
  logic        Imem2proc_rvalid;
  logic [31:0] Imem2proc_data;
  logic        id_ready;
  logic        if_valid_inst_out;
  logic [31:0] if_PC_out;
  logic [31:0] if_NPC_out;
  logic [31:0] if_IR_out;

  if_prefetch_stage #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ex_take_branch_out (ex_take_branch_out),
    .ex_target_PC_out   (ex_target_PC_out),
    .proc2Imem_req      (proc2Imem_req),
    .proc2Imem_addr     (proc2Imem_addr),
    .Imem2proc_gnt      (Imem2proc_gnt),
    .Imem2proc_rvalid   (Imem2proc_rvalid),
    .Imem2proc_data     (Imem2proc_data),
    .id_ready           (id_ready),
    .if_valid_inst_out  (if_valid_inst_out),
    .if_PC_out          (if_PC_out),
    .if_NPC_out         (if_NPC_out),
    .if_IR_out          (if_IR_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model: live fetched PCs in program order; the first m_filled of
  // them have data. stale counts wrong-path responses still to come back.
  logic [31:0] mq [$];
  int          m_filled;
  int          stale;
  logic [31:0] fpc;

  // Memory model: granted addresses and the cycle each may respond (in order).
  logic [31:0] pend_addr [$];
  int          pend_due  [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0000;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    pend_addr.delete();
    pend_due.delete();
    m_filled = 0;
    stale    = 0;
    fpc      = RESET_PC;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n              = 1'b0;
    ex_take_branch_out = 1'b0;
    ex_target_PC_out   = '0;
    Imem2proc_gnt      = 1'b0;
    Imem2proc_rvalid   = 1'b0;
    Imem2proc_data     = '0;
    id_ready           = 1'b0;
    #1;
    check_eq("rst_req", 32'(proc2Imem_req), 32'd0);
    check_eq("rst_valid", 32'(if_valid_inst_out), 32'd0);
    model_clear();
    @(negedge clk);
    #1;
    check_eq("rst_req_held", 32'(proc2Imem_req), 32'd0);
    rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare outputs, advance the model.
  task automatic step(input bit br, input logic [31:0] tgt, input bit gnt, input bit rdy,
                      input int k);
    bit rv, exp_req, exp_valid;
    int outst;
    @(negedge clk);
    rv = (pend_due.size() > 0) && (pend_due[0] <= cyc);
    ex_take_branch_out = br;
    ex_target_PC_out   = tgt;
    Imem2proc_gnt      = gnt;
    id_ready           = rdy;
    Imem2proc_rvalid   = rv;
    Imem2proc_data     = rv ? mem_word(pend_addr[0]) : $urandom;
    #1;
    exp_req   = !br && (mq.size() + stale < DEPTH);
    exp_valid = (m_filled > 0);
    check_eq("req", 32'(proc2Imem_req), 32'(exp_req));
    if (exp_req) check_eq("addr", proc2Imem_addr, fpc);
    check_eq("valid", 32'(if_valid_inst_out), 32'(exp_valid));
    if (exp_valid) begin
      check_eq("pc", if_PC_out, mq[0]);
      check_eq("npc", if_NPC_out, mq[0] + 32'd4);
      check_eq("ir", if_IR_out, mem_word(mq[0]));
    end
    if (rv) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (br) begin
      outst    = mq.size() - m_filled;
      stale    = stale + outst - (rv ? 1 : 0);
      mq.delete();
      m_filled = 0;
      fpc      = {tgt[31:2], 2'b00};
    end else begin
      if (rv) begin
        if (stale > 0) stale--;
        else if (m_filled < mq.size()) m_filled++;
      end
      if (exp_valid && rdy) begin
        void'(mq.pop_front());
        m_filled--;
      end
      if (exp_req && gnt) begin
        mq.push_back(fpc);
        pend_addr.push_back(fpc);
        pend_due.push_back(cyc + k);
        fpc = fpc + 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    model_clear();
    do_reset();
    // Streaming, latency 1, decode always ready.
    repeat (20) step(1'b0, 32'h0, 1'b1, 1'b1, 1);
    // Decode stall fills the buffer, then drains.
    repeat (10) step(1'b0, 32'h0, 1'b1, 1'b0, 1);
    repeat (10) step(1'b0, 32'h0, 1'b1, 1'b1, 2);
    // Memory withholds grant.
    repeat (5)  step(1'b0, 32'h0, 1'b0, 1'b1, 1);
    // Build up outstanding requests, then redirect to an unaligned target.
    repeat (3)  step(1'b0, 32'h0, 1'b1, 1'b0, 4);
    step(1'b1, 32'h103, 1'b1, 1'b1, 1);
    repeat (15) step(1'b0, 32'h0, 1'b1, 1'b1, 1);
    // Randomized traffic with a reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step($urandom_range(0, 19) == 0, $urandom & 32'h0000_FFFF,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(1, 4));
    end
    repeat (20) step(1'b0, 32'h0, 1'b1, 1'b1, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/if_prefetch_stage.md
Name: if_prefetch_stage

Overview:
Parametrised instruction-fetch stage with a DEPTH-entry in-order prefetch buffer. It supports multiple outstanding requests to a variable-latency instruction memory using a request/grant/response handshake. Branch redirects flush the buffer, and wrong-path responses still in flight are discarded. It sits between instruction memory and decode, replacing the single-PC fetch with stall-only flow control.

Parameters:
XLEN, 32, width of PC, address and instruction
DEPTH, 4, prefetch buffer entries and max outstanding requests; power of 2, >= 2
RESET_PC, 32'h0, fetch PC after reset

Ports:
clk  input  1  system clock
rst_n  input  1  reset; one clock; asynchronous, active-low
ex_take_branch_out  input  1  redirect request from EX
ex_target_PC_out  input  XLEN  redirect target; valid when ex_take_branch_out=1
proc2Imem_req  output  1  fetch request valid
proc2Imem_addr  output  XLEN  fetch address, word aligned
Imem2proc_gnt  input  1  memory accepts the request this cycle
Imem2proc_rvalid  input  1  in-order response valid
Imem2proc_data  input  XLEN  response instruction word
id_ready  input  1  decode accepts the head instruction; 0 = stall
if_valid_inst_out  output  1  head instruction valid
if_PC_out  output  XLEN  head PC
if_NPC_out  output  XLEN  head PC + 4
if_IR_out  output  XLEN  head instruction

Behaviour:
- Reset (rst_n=0, async): fetch_pc=RESET_PC; all pointers, counters and entry flags = 0. proc2Imem_req=0 and if_valid_inst_out=0 while reset is held. Data outputs are don't-care.
- Buffer uses three pointers: alloc, fill, read, each of width $clog2(DEPTH)+1 with a wrap bit.
  - occupancy = alloc - read.
  - outstanding = alloc - fill.
- Issue: proc2Imem_req = rst_n & !ex_take_branch_out & (occupancy + drop_cnt < DEPTH).
- proc2Imem_addr = {fetch_pc[XLEN-1:2], 2'b00}.
- req & gnt: allocate the entry at alloc (store PC, filled=0), alloc++, fetch_pc += 4 (wraps modulo 2^XLEN).
- Memory may hold gnt low indefinitely. req and addr stay stable until granted or a redirect occurs.
- Response with drop_cnt>0: data discarded, drop_cnt--.
- Response with drop_cnt=0 and outstanding>0: write IR into the entry at fill, set filled, fill++.
- Response with drop_cnt=0 and outstanding=0: ignored; assertion fires (protocol error).
- Output is driven from registers only; there is no combinational path from Imem2proc_*.
  - if_valid_inst_out = (read != fill).
  - PC and IR come from the entry at read; NPC = PC + 4.
- Pop on if_valid_inst_out & id_ready: read++.
- Latency: grant in cycle t, rvalid at t+k (k >= 1), output valid at t+k+1.
- Back-to-back: one instruction per cycle at steady state when k <= DEPTH-1.
- Redirect (ex_take_branch_out=1), which has priority over everything else:
  - next cycle: read = fill = alloc = 0, all filled flags cleared, fetch_pc = {target[XLEN-1:2], 2'b00}.
  - drop_cnt_next = drop_cnt + outstanding - (rvalid this cycle ? 1 : 0).
  - No request is issued in the redirect cycle.
  - A pop in the same cycle is ignored.
  - A response in the same cycle is discarded.
  - if_valid_inst_out=0 in the cycle after the redirect.
- Full: occupancy + drop_cnt = DEPTH blocks issue. A pop frees a slot for issue in the next cycle.
- Empty: if_valid_inst_out=0; id_ready is ignored.
- Back-to-back redirects: each one re-accumulates drop_cnt. The last target wins.
- drop_cnt width is $clog2(DEPTH)+1 and never exceeds DEPTH.

Decomposition:
- Package if_pkg:
  - XLEN_DEF.
  - INST_BYTES=4.
  - typedef fetch_entry_t {logic filled; logic [XLEN-1:0] pc; logic [XLEN-1:0] ir;}.
  - Pointer-width function ptr_w(depth).
- Sub-module if_fetch_buf:
  - holds the DEPTH-entry circular buffer and the alloc/fill/read pointers.
  - alloc/fill/pop/flush strobes.
  - occupancy/outstanding outputs.
- Top level: fetch_pc, issue logic, drop_cnt and redirect control.

Test Plan:
- Reset then zero-latency-1 memory with gnt=1 and id_ready=1 -> addrs 0,4,8,... issued each cycle; if_valid_inst_out from cycle 3; PCs 0,4,8 in order with NPC = PC+4.
- id_ready=0 with DEPTH=4, k=1 -> exactly 4 grants, then req=0; buffer holds PCs 0..C. Raise id_ready -> one pop per cycle, and req resumes the cycle after the first pop.
- 3 requests outstanding, redirect to 0x103 -> next addr 0x100; 3 stale responses dropped; first delivered instruction has PC 0x100 with IR from the 4th response.
- Redirect in the same cycle as rvalid and id_ready=1 with a valid head -> that response is dropped, the head is not counted as consumed, drop_cnt = outstanding-1.
- gnt held 0 for 5 cycles -> req/addr stable at 0x8 throughout; fetch_pc advances only on grant.
- Assert rst_n=0 mid-stream with 2 outstanding -> outputs deassert immediately. After release, fetch restarts at RESET_PC and no stale data appears (memory is reset alongside).
